// File: rtl/mux_arb.sv
// mux_arb: round-robin arbiter for four requesters driving 74x253/257-style
// bus muxes. Every bus handover passes through a one-cycle SETUP dead cycle
// (grant and output enable off, new select) so the muxes break before make.
// Optional feature: define MUX_ARB_TIMEOUT_EN to preempt an owner that has
// held the bus for TENURE cycles while another requester is waiting.
module mux_arb #(
    parameter int unsigned TENURE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       oe_n,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OWN   = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] last_owner;

    // TENURE must fit the 8-bit tenure counter
    if (TENURE < 1 || TENURE > 255) begin : g_bad_tenure
        $error("mux_arb: TENURE out of range 1..255");
    end

`ifdef MUX_ARB_TIMEOUT_EN
    localparam logic [7:0] LIMIT = 8'(TENURE - 1);

    logic [7:0] cnt;
    logic [3:0] others;

    // requests from everyone except the current owner
    always_comb begin
        others = req & ~(4'b0001 << sel);
    end
`endif

    // First set request bit searching base+1, base+2, base+3, base+4 (mod 4)
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = base;
        found = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = base + 2'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Arbitration FSM with all outputs registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= '0;
            sel        <= '0;
            oe_n       <= 1'b1;
            busy       <= 1'b0;
            last_owner <= 2'd3;
`ifdef MUX_ARB_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    gnt  <= '0;
                    oe_n <= 1'b1;
                    if (|req) begin
                        sel   <= rr_pick(req, last_owner);
                        busy  <= 1'b1;
                        state <= SETUP;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                SETUP: begin
                    if (req[sel]) begin
                        gnt        <= 4'b0001 << sel;
                        oe_n       <= 1'b0;
                        last_owner <= sel;
`ifdef MUX_ARB_TIMEOUT_EN
                        cnt        <= '0;
`endif
                        state      <= OWN;
                    end else begin
                        // winner let go during the dead cycle: abandon
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                OWN: begin
                    if (!req[sel]) begin
                        // release path also covers a drop coinciding with timeout
                        gnt  <= '0;
                        oe_n <= 1'b1;
                        if (|req) begin
                            sel   <= rr_pick(req, sel);
                            state <= SETUP;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
`ifdef MUX_ARB_TIMEOUT_EN
                    else if (cnt == LIMIT && |others) begin
                        gnt   <= '0;
                        oe_n  <= 1'b1;
                        sel   <= rr_pick(others, sel);
                        state <= SETUP;
                    end else if (cnt != LIMIT) begin
                        // saturates at LIMIT until a competitor shows up
                        cnt <= cnt + 8'd1;
                    end
`endif
                end

                default: begin
                    gnt   <= '0;
                    oe_n  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_arb.sv
// Directed testbench for mux_arb (instantiated with TENURE=4).
module tb_mux_arb;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       oe_n;
    logic       busy;

    int n_checks;
    int n_fail;

    mux_arb #(.TENURE(4)) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .gnt  (gnt),
        .sel  (sel),
        .oe_n (oe_n),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_setup(input string tag, input logic [1:0] s);
        check({tag, "_gnt"}, 8'(gnt), 8'h0);
        check({tag, "_oe_n"}, 8'(oe_n), 8'h1);
        check({tag, "_sel"}, 8'(sel), 8'(s));
        check({tag, "_busy"}, 8'(busy), 8'h1);
    endtask

    task automatic chk_own(input string tag, input logic [1:0] o);
        check({tag, "_gnt"}, 8'(gnt), 8'(4'b0001 << o));
        check({tag, "_oe_n"}, 8'(oe_n), 8'h0);
        check({tag, "_sel"}, 8'(sel), 8'(o));
        check({tag, "_busy"}, 8'(busy), 8'h1);
    endtask

    task automatic chk_idle(input string tag, input logic [1:0] s);
        check({tag, "_gnt"}, 8'(gnt), 8'h0);
        check({tag, "_oe_n"}, 8'(oe_n), 8'h1);
        check({tag, "_sel"}, 8'(sel), 8'(s));
        check({tag, "_busy"}, 8'(busy), 8'h0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        req      = 4'b0000;
        #1;
        chk_idle("reset", 2'd0);
        tick();
        tick();
        reset = 1'b0;

        // first arbitration after reset favours requester 0
        req = 4'b0101;
        tick();
        chk_setup("first_setup", 2'd0);
        tick();
        chk_own("first_own", 2'd0);

        // owner 0 drops, 1 and 2 pending -> 1 wins after one dead cycle
        req = 4'b0110;
        tick();
        chk_setup("handover_setup", 2'd1);
        tick();
        chk_own("handover_own", 2'd1);

        // asynchronous reset mid-OWN takes effect before the next edge
        #1;
        reset = 1'b1;
        #1;
        chk_idle("async_reset", 2'd0);
        req = 4'b0000;
        tick();
        reset = 1'b0;
        tick();
        chk_idle("post_reset", 2'd0);

        // all requesting, each owner releases after 3 OWN cycles: 0,1,2,3,0
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] k;
            k = 2'(i % 4);
            tick();
            chk_setup($sformatf("rr%0d_setup", i), k);
            req = 4'b1111;
            for (int j = 0; j < 3; j++) begin
                tick();
                chk_own($sformatf("rr%0d_own%0d", i, j), k);
            end
            req = 4'b1111 & ~(4'b0001 << k);
        end
        req = 4'b0000;
        tick();
        chk_idle("rr_done", 2'd0);

        // one-cycle pulse: SETUP then abandoned, sel holds
        req = 4'b0100;
        tick();
        chk_setup("pulse_setup", 2'd2);
        req = 4'b0000;
        tick();
        chk_idle("pulse_idle", 2'd2);
        tick();
        chk_idle("pulse_hold", 2'd2);

        // last_owner still 0 after abandon: search 1,2,3 -> 3 beats 0
        req = 4'b1001;
        tick();
        chk_setup("rr_base_setup", 2'd3);
        tick();
        chk_own("rr_base_own", 2'd3);
        req = 4'b0000;
        tick();
        chk_idle("rr_base_idle", 2'd3);

        // tenure behaviour with req=0011 held
        pulse_reset();
        req = 4'b0011;
        tick();
        chk_setup("ten_setup", 2'd0);
`ifdef MUX_ARB_TIMEOUT_EN
        for (int r = 0; r < 4; r++) begin
            logic [1:0] o;
            o = 2'(r % 2);
            for (int c = 0; c < 4; c++) begin
                tick();
                chk_own($sformatf("ten%0d_own%0d", r, c), o);
            end
            tick();
            chk_setup($sformatf("ten%0d_preempt", r), ~o & 2'd1);
        end
        // saturation: lone owner, competitor appears late -> immediate preempt
        req = 4'b0000;
        tick();
        pulse_reset();
        req = 4'b0001;
        tick();
        chk_setup("sat_setup", 2'd0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk_own($sformatf("sat_own%0d", c), 2'd0);
        end
        req = 4'b0011;
        tick();
        chk_setup("sat_preempt", 2'd1);
`else
        for (int c = 0; c < 20; c++) begin
            tick();
            chk_own($sformatf("hold_own%0d", c), 2'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 Parameter TENURE, default 16: OWN cycles before preemption when another request is pending; legal range 1..255.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  request lines, one per requester, level-sensitive, bit i = requester i.
REQ-005 gnt  output  4  registered one-hot grant; all zero when no owner.
REQ-006 sel  output  2  registered select, wired to sel of 74x253/257-style bus muxes.
REQ-007 oe_n  output  1  registered active-low mux output enable; 1 = bus tri-stated.
REQ-008 busy  output  1  registered; 1 in states SETUP and OWN.

Function
REQ-009 States: IDLE, SETUP, OWN; encoding is free, transitions as below only.
REQ-010 IDLE: gnt=0, oe_n=1, sel holds last value; if any req bit set, pick winner, load sel=winner, go SETUP.
REQ-011 Winner: round-robin, search order last_owner+1, +2, +3, +4 (mod 4); first set req bit wins.
REQ-012 SETUP (exactly one cycle, break-before-make dead cycle): gnt=0, oe_n=1, sel=winner.
REQ-013 SETUP exit: if req[winner]=1, go OWN; else go IDLE (abandoned, last_owner unchanged).
REQ-014 OWN: gnt=one-hot(sel), oe_n=0, last_owner=sel on entry, tenure counter cleared on entry.
REQ-015 Latency: req sampled high in IDLE at edge n; sel valid after n, gnt and oe_n=0 after n+1.
REQ-016 OWN exit on req[owner]=0: if other req pending, go SETUP with new winner; else go IDLE.
REQ-017 gnt and oe_n never change in the same cycle as sel; sel changes only on entry to SETUP.
REQ-018 A requester keeping req high retains OWN indefinitely unless preempted per REQ-025.
REQ-019 A released owner re-requesting immediately is searched last (round-robin fairness).
REQ-020 Requests arriving during SETUP or OWN are not latched; only current levels are evaluated.
REQ-021 At most one gnt bit is 1 in any cycle; oe_n=0 iff exactly one gnt bit is 1.

Reset
REQ-022 On reset high, immediately and without clk: state=IDLE, gnt=0, sel=0, oe_n=1, busy=0, last_owner=3, counter=0.
REQ-023 Reset mid-OWN or mid-SETUP aborts the tenure; no grant is restored after reset release.
REQ-024 First arbitration after reset favours requester 0 (last_owner=3).

Configuration
REQ-025 With MUX_ARB_TIMEOUT_EN defined: 8-bit counter increments each OWN cycle; when counter=TENURE-1 and any other req bit set, next state SETUP with winner chosen excluding the owner.
REQ-026 With MUX_ARB_TIMEOUT_EN defined: counter saturates at TENURE-1 when no other request is pending; preemption occurs the first cycle one appears.
REQ-027 With MUX_ARB_TIMEOUT_EN defined: owner dropping req in the same cycle as timeout takes the normal release path; result is identical.
REQ-028 Without MUX_ARB_TIMEOUT_EN: no counter, TENURE ignored, OWN ends only on req[owner]=0.

Verification
REQ-029 After reset, req=4'b0101 held -> sel=0 after edge 1, gnt=4'b0001 and oe_n=0 after edge 2.
REQ-030 Owner 0 drops req while req=4'b0110 -> one SETUP cycle (gnt=0, oe_n=1, sel=1), then gnt=4'b0010.
REQ-031 req=4'b1111 held, each owner releases after 3 OWN cycles -> grant order 0,1,2,3,0 with one dead cycle between tenures.
REQ-032 req=4'b0100 pulsed for one cycle only -> SETUP then IDLE, gnt stays 0, oe_n stays 1.
REQ-033 MUX_ARB_TIMEOUT_EN, TENURE=4, req=4'b0011 held -> owner 0 for 4 cycles, SETUP, owner 1 for 4 cycles, repeat; without macro owner 0 holds forever.
REQ-034 reset asserted mid-OWN (gnt=4'b0010) -> gnt=0, oe_n=1, sel=0 before next clk edge.
